seg7_scan_decoder: RTL and testbench

- Receive side of the 7-segment display interface: samples a multiplexed, active-low segment/anode bus and recovers the BCD digit shown on each position.
- Uses the team's standard pattern set: gfedcba, active-low, digits 0-9.
- Applies per-digit stability filtering, flags illegal patterns and emits an update strobe.
- Used by the processor test harness to read back display output and by loopback checks of the display driver path.

---
 rtl/seg7_scan_decoder.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus, with per-position stability filter.
// Latency: sample -> filter state on edge k, committed digits/valid/err/upd on edge k+1; an_err one edge after a bad select.
// No backpressure: the bus is observed every cycle and there is no flow control on either side.
module seg7_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   an,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   err,
  output logic              upd,
  output logic              an_err
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);

  typedef enum logic [1:0] {PAT_DIGIT, PAT_BLANK, PAT_ILLEGAL} pat_class_e;

  typedef struct packed {
    pat_class_e cls;
    logic [3:0] val;
  } dec_t;

  // gfedcba active-low pattern classifier
  function automatic dec_t decode(input logic [6:0] p);
    dec_t d;
    d.cls = PAT_DIGIT;
    d.val = 4'd0;
    case (p)
      7'b1000000: d.val = 4'd0;
      7'b1111001: d.val = 4'd1;
      7'b0100100: d.val = 4'd2;
      7'b0110000: d.val = 4'd3;
      7'b0011001: d.val = 4'd4;
      7'b0010010: d.val = 4'd5;
      7'b0000010: d.val = 4'd6;
      7'b1111000: d.val = 4'd7;
      7'b0000000: d.val = 4'd8;
      7'b0010000: d.val = 4'd9;
      7'b1111111: d.cls = PAT_BLANK;
      default:    d.cls = PAT_ILLEGAL;
    endcase
    return d;
  endfunction

  logic [6:0]    last_pat [NDIG];
  logic [CW-1:0] cnt      [NDIG];

  // commit pipeline register between filter and output stage
  logic          cm_vld;
  logic [IW-1:0] cm_idx;
  logic [6:0]    cm_pat;

  logic [NDIG-1:0] an_low;
  logic            sample;
  logic            bad_sel;
  logic [IW-1:0]   sel_idx;
  logic            same;
  logic            saturated;
  logic [CW-1:0]   nxt_cnt;
  logic            commit;

  // decode the anode bus: which position (if any) is being driven this cycle
  always_comb begin
    an_low  = ~an;
    sample  = $onehot(an_low);
    bad_sel = !sample && (an_low != '0);
    sel_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (an_low[i]) sel_idx = IW'(i);
    end
  end

  // stability filter for the selected position; commit fires once, when the count first reaches STABLE
  always_comb begin
    same      = (seg == last_pat[sel_idx]);
    saturated = same && (cnt[sel_idx] == CNT_MAX);
    if (!same)          nxt_cnt = CW'(1);
    else if (saturated) nxt_cnt = cnt[sel_idx];
    else                nxt_cnt = cnt[sel_idx] + CW'(1);
    commit = sample && !saturated && (nxt_cnt == CNT_MAX);
  end

  // filter state, commit request and select-error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) begin
        last_pat[i] <= 7'h7F;
        cnt[i]      <= '0;
      end
      cm_vld <= 1'b0;
      cm_idx <= '0;
      cm_pat <= 7'h7F;
      an_err <= 1'b0;
    end else begin
      an_err <= bad_sel;
      cm_vld <= commit;
      cm_idx <= sel_idx;
      cm_pat <= seg;
      if (sample) begin
        last_pat[sel_idx] <= seg;
        cnt[sel_idx]      <= nxt_cnt;
      end
    end
  end

  dec_t       cm_dec;
  logic [3:0] old_dig;
  logic [3:0] new_dig;
  logic       new_vld;
  logic       new_err;
  logic       changed;

  // resulting outputs for the committing position and whether anything actually moves
  always_comb begin
    cm_dec  = decode(cm_pat);
    old_dig = digits[{cm_idx, 2'b00} +: 4];
    new_dig = (cm_dec.cls == PAT_DIGIT) ? cm_dec.val : old_dig;
    new_vld = (cm_dec.cls == PAT_DIGIT);
    new_err = (cm_dec.cls == PAT_ILLEGAL);
    changed = cm_vld && ((new_dig != old_dig) || (new_vld != valid[cm_idx]) ||
                         (new_err != err[cm_idx]));
  end

  // registered outputs; upd only when a commit alters something
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits <= '0;
      valid  <= '0;
      err    <= '0;
      upd    <= 1'b0;
    end else begin
      upd <= changed;
      if (cm_vld) begin
        digits[{cm_idx, 2'b00} +: 4] <= new_dig;
        valid[cm_idx]                <= new_vld;
        err[cm_idx]                  <= new_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans patterns onto the bus and checks recovered outputs.
// Inputs change 1ns after the falling edge; outputs are read at the same point.
// Pulse counters sample upd/an_err on the falling edge.
module tb_seg7_scan_decoder;

  localparam logic [6:0] P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000, P8 = 7'b0000000, P9 = 7'b0010000;
  localparam logic [6:0] PBLANK = 7'b1111111, PILL = 7'b0101010;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;
  logic        an_err;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  int an_err_cnt = 0;
  int base;

  seg7_scan_decoder #(.NDIG(4), .STABLE(3)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an),
    .digits(digits), .valid(valid), .err(err), .upd(upd), .an_err(an_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd)    upd_cnt++;
    if (an_err) an_err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an_v, input logic [6:0] seg_v);
    @(negedge clk);
    #1;
    an  = an_v;
    seg = seg_v;
  endtask

  task automatic scan(input int p, input logic [6:0] s, input int n);
    logic [3:0] m;
    m = 4'b0001 << p;
    repeat (n) drive(~m, s);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'hF, 7'h7F);
  endtask

  initial begin
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    idle(3);
    check("rst_digits", digits, 16'h0);
    check("rst_valid", valid, 4'h0);
    check("rst_err", err, 4'h0);
    check("rst_upd", upd, 1'b0);
    check("rst_an_err", an_err, 1'b0);
    reset = 1'b0;

    // 1: round-robin 1,2,3,4
    base = upd_cnt;
    for (int r = 0; r < 3; r++) begin
      scan(0, P1, 1);
      scan(1, P2, 1);
      scan(2, P3, 1);
      scan(3, P4, 1);
    end
    idle(1);
    check("t1_latency_digits", digits, 16'h0321);
    idle(1);
    check("t1_digits", digits, 16'h4321);
    check("t1_valid", valid, 4'hF);
    check("t1_err", err, 4'h0);
    idle(2);
    check("t1_upd_count", upd_cnt - base, 4);

    // 2: flicker 6,6 then 5,5,5 on position 2
    base = upd_cnt;
    scan(2, P6, 2);
    scan(2, P5, 3);
    idle(1);
    check("t2_pre_commit", digits[11:8], 4'h3);
    idle(1);
    check("t2_digit", digits[11:8], 4'h5);
    check("t2_valid", valid[2], 1'b1);
    idle(1);
    check("t2_upd_count", upd_cnt - base, 1);

    // 3: position 1 holds 7, then illegal pattern
    scan(1, P7, 3);
    idle(2);
    check("t3_hold7", digits[7:4], 4'h7);
    base = upd_cnt;
    scan(1, PILL, 3);
    idle(1);
    check("t3_err_latency", err[1], 1'b0);
    check("t3_upd_latency", upd, 1'b0);
    idle(1);
    check("t3_upd_pulse", upd, 1'b1);
    check("t3_err", err[1], 1'b1);
    check("t3_valid", valid[1], 1'b0);
    check("t3_digit_held", digits[7:4], 4'h7);
    idle(2);
    check("t3_upd_count", upd_cnt - base, 1);

    // 4: position 0 holds 9, then blank
    scan(0, P9, 3);
    idle(2);
    check("t4_hold9_valid", valid[0], 1'b1);
    scan(0, PBLANK, 3);
    idle(2);
    check("t4_valid", valid[0], 1'b0);
    check("t4_err", err[0], 1'b0);
    check("t4_digit_held", digits[3:0], 4'h9);

    // 5: bad select and idle select
    base = an_err_cnt;
    drive(4'b0011, 7'b0000000);
    idle(1);
    check("t5_an_err_pulse", an_err, 1'b1);
    idle(1);
    check("t5_an_err_clear", an_err, 1'b0);
    check("t5_an_err_count", an_err_cnt - base, 1);
    check("t5_digits", digits, 16'h4579);
    check("t5_valid", valid, 4'b1100);
    check("t5_err", err, 4'b0010);
    base = an_err_cnt;
    repeat (3) drive(4'b1111, 7'b0000000);
    idle(1);
    check("t5_idle_no_an_err", an_err_cnt - base, 0);
    check("t5_idle_digits", digits, 16'h4579);

    // 6: reset mid-filter on position 3
    scan(3, P8, 2);
    @(negedge clk);
    #1;
    reset = 1'b1;
    an    = 4'hF;
    idle(2);
    check("t6_rst_digits", digits, 16'h0);
    check("t6_rst_valid", valid, 4'h0);
    check("t6_rst_err", err, 4'h0);
    reset = 1'b0;
    scan(3, P8, 1);
    idle(2);
    check("t6_one_scan_valid", valid, 4'h0);
    check("t6_one_scan_digits", digits, 16'h0);
    scan(3, P8, 2);
    idle(2);
    check("t6_digits", digits, 16'h8000);
    check("t6_valid", valid, 4'b1000);

    // saturated count: a further identical scan must not re-commit
    base = upd_cnt;
    scan(3, P8, 2);
    idle(3);
    check("t6_saturate_no_upd", upd_cnt - base, 0);
    check("t6_saturate_digits", digits, 16'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
